// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and the MEM-stage data port.
// Data-first priority; completed results are buffered while the pipeline is held.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipe_hold_i,
  input  logic          flush_i,
  input  logic          if_ce_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_stallreq_o,
  input  logic          dm_ce_i,
  input  logic          dm_we_i,
  input  logic [3:0]    dm_sel_i,
  input  logic [AW-1:0] dm_addr_i,
  input  logic [DW-1:0] dm_wdata_i,
  output logic [DW-1:0] dm_rdata_o,
  output logic          dm_stallreq_o,
  output logic          bus_req_o,
  output logic          bus_we_o,
  output logic [3:0]    bus_sel_o,
  output logic [AW-1:0] bus_addr_o,
  output logic [DW-1:0] bus_wdata_o,
  input  logic          bus_ack_i,
  input  logic [DW-1:0] bus_rdata_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, INST = 2'd2} state_t;

  state_t        state;
  state_t        state_next;
  logic          dm_done;
  logic          if_done;
  logic          inst_flushed;
  logic [DW-1:0] dm_hold;
  logic [DW-1:0] if_hold;
  logic          dm_pend;
  logic          if_pend;
  logic          dm_ack;
  logic          if_ack;
  logic          dm_keep;
  logic          if_keep;

  assign dm_pend = dm_ce_i & ~dm_done;
  assign if_pend = if_ce_i & ~if_done;
  assign dm_ack  = (state == DATA) & bus_ack_i;
  assign if_ack  = (state == INST) & bus_ack_i;
  // A fetch result is dropped if a flush arrived at any point during its transaction.
  assign dm_keep = dm_ack & dm_ce_i;
  assign if_keep = if_ack & if_ce_i & ~flush_i & ~inst_flushed;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (dm_pend) begin
          state_next = DATA;
        end else if (if_pend) begin
          state_next = INST;
        end else begin
          state_next = IDLE;
        end
      end
      DATA, INST: begin
        if (bus_ack_i) begin
          state_next = IDLE;
        end else begin
          state_next = state;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus request registers, launched from IDLE and held until ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_sel_o   <= 4'b0000;
      bus_addr_o  <= {AW{1'b0}};
      bus_wdata_o <= {DW{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (dm_pend) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= dm_we_i;
            bus_sel_o   <= dm_sel_i;
            bus_addr_o  <= dm_addr_i;
            bus_wdata_o <= dm_wdata_i;
          end else if (if_pend) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= 4'b1111;
            bus_addr_o  <= if_addr_i;
          end else begin
            bus_req_o   <= 1'b0;
          end
        end
        DATA, INST: begin
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
          end else begin
            bus_req_o <= bus_req_o;
          end
        end
        default: bus_req_o <= 1'b0;
      endcase
    end
  end

  // Done flags and result hold registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dm_done      <= 1'b0;
      if_done      <= 1'b0;
      inst_flushed <= 1'b0;
      dm_hold      <= {DW{1'b0}};
      if_hold      <= {DW{1'b0}};
    end else begin
      if (!pipe_hold_i) begin
        dm_done <= 1'b0;
      end else if (dm_keep) begin
        dm_done <= 1'b1;
      end else begin
        dm_done <= dm_done;
      end
      if (!pipe_hold_i || flush_i) begin
        if_done <= 1'b0;
      end else if (if_keep) begin
        if_done <= 1'b1;
      end else begin
        if_done <= if_done;
      end
      if (if_ack) begin
        inst_flushed <= 1'b0;
      end else if ((state == INST) && flush_i) begin
        inst_flushed <= 1'b1;
      end else begin
        inst_flushed <= inst_flushed;
      end
      if (dm_keep && !bus_we_o) begin
        dm_hold <= bus_rdata_i;
      end
      if (if_keep) begin
        if_hold <= bus_rdata_i;
      end
    end
  end

  // Port outputs: ack-cycle passthrough, otherwise the held result
  always_comb begin
    if (if_ack) begin
      if_rdata_o = bus_rdata_i;
    end else begin
      if_rdata_o = if_hold;
    end
    if (dm_ack) begin
      dm_rdata_o = bus_rdata_i;
    end else begin
      dm_rdata_o = dm_hold;
    end
    if_stallreq_o = if_ce_i & ~if_done & ~if_ack;
    dm_stallreq_o = dm_ce_i & ~dm_done & ~dm_ack;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected bus transactions,
// a negedge monitor pops and checks them as the DUT launches and completes each one.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pipe_hold_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        if_ce_i = 1'b0;
  logic [31:0] if_addr_i = 32'h0;
  logic [31:0] if_rdata_o;
  logic        if_stallreq_o;
  logic        dm_ce_i = 1'b0;
  logic        dm_we_i = 1'b0;
  logic [3:0]  dm_sel_i = 4'b0000;
  logic [31:0] dm_addr_i = 32'h0;
  logic [31:0] dm_wdata_i = 32'h0;
  logic [31:0] dm_rdata_o;
  logic        dm_stallreq_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i = 1'b0;
  logic [31:0] bus_rdata_i = 32'h0;

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .pipe_hold_i(pipe_hold_i), .flush_i(flush_i),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
    .if_stallreq_o(if_stallreq_o),
    .dm_ce_i(dm_ce_i), .dm_we_i(dm_we_i), .dm_sel_i(dm_sel_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o), .dm_stallreq_o(dm_stallreq_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_data;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_at;
    logic        chk_rd;
  } txn_t;

  txn_t exp_q[$];
  txn_t cur;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic push(input logic is_data, input logic we, input logic [3:0] sel,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rdata, input int ack_at, input logic chk_rd);
    txn_t t;
    t.is_data = is_data; t.we = we; t.sel = sel; t.addr = addr;
    t.wdata = wdata; t.rdata = rdata; t.ack_at = ack_at; t.chk_rd = chk_rd;
    exp_q.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus responder: acks the N-th request cycle, N taken from the expected transaction
  logic        force_ack = 1'b0;
  int          rcnt = 0;
  int          r_at = 2;
  logic [31:0] r_data = 32'h0;
  always begin
    @(posedge clk);
    #1;
    if (bus_req_o) begin
      if (rcnt == 0) begin
        if (exp_q.size() > 0) begin
          r_at = exp_q[0].ack_at;
          r_data = exp_q[0].rdata;
        end else begin
          r_at = 2;
          r_data = 32'h0;
        end
      end
      rcnt++;
      bus_ack_i = (rcnt == r_at) | force_ack;
      bus_rdata_i = r_data;
    end else begin
      rcnt = 0;
      bus_ack_i = force_ack;
      bus_rdata_i = 32'h0;
    end
  end

  // Monitor: pops on transaction start, checks latency, stability and the served port at ack
  logic        in_txn = 1'b0;
  int          req_cycles = 0;
  logic [40:0] st_fields;
  always @(negedge clk) begin
    if (!rst) begin
      in_txn = 1'b0;
    end else begin
      if (bus_req_o && !in_txn) begin
        in_txn = 1'b1;
        req_cycles = 0;
        st_fields = {bus_addr_o, bus_sel_o, bus_we_o, bus_wdata_o[3:0]};
        chk("txn_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
        end else begin
          cur.is_data = 1'b0; cur.we = 1'b0; cur.sel = 4'b0; cur.addr = 32'h0;
          cur.wdata = 32'h0; cur.rdata = 32'h0; cur.ack_at = 0; cur.chk_rd = 1'b0;
        end
        chk("bus_addr", bus_addr_o, cur.addr);
        chk("bus_we", 32'(bus_we_o), 32'(cur.we));
        chk("bus_sel", 32'(bus_sel_o), 32'(cur.sel));
        if (cur.we) chk("bus_wdata", bus_wdata_o, cur.wdata);
      end
      if (in_txn && bus_req_o) begin
        req_cycles++;
        if (bus_ack_i) begin
          chk("ack_latency", 32'(req_cycles), 32'(cur.ack_at));
          chk("bus_stable", 32'({bus_addr_o, bus_sel_o, bus_we_o, bus_wdata_o[3:0]} == st_fields), 32'd1);
          chk("ack_stall", 32'(cur.is_data ? dm_stallreq_o : if_stallreq_o), 32'd0);
          if (cur.chk_rd) chk("ack_rdata", cur.is_data ? dm_rdata_o : if_rdata_o, cur.rdata);
          in_txn = 1'b0;
        end
      end
    end
  end

  task automatic wait_quiet(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus_req_o && !in_txn) done = 1'b1;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_bus_req", 32'(bus_req_o), 32'd0);
    chk("rst_bus_addr", bus_addr_o, 32'h0);
    chk("rst_bus_sel", 32'(bus_sel_o), 32'd0);
    chk("rst_if_rdata", if_rdata_o, 32'h0);
    chk("rst_dm_rdata", dm_rdata_o, 32'h0);
    chk("rst_stalls", 32'({if_stallreq_o, dm_stallreq_o}), 32'd0);
    rst = 1'b1;

    // Single fetch, ack in the 2nd request cycle
    push(1'b0, 1'b0, 4'b1111, 32'h100, 32'h0, 32'h3C010001, 2, 1'b1);
    tick(); if_ce_i = 1'b1; if_addr_i = 32'h100; pipe_hold_i = 1'b0;
    @(negedge clk); chk("f1_stall_c0", 32'(if_stallreq_o), 32'd1);
    tick(); @(negedge clk);
    chk("f1_req_c1", 32'(bus_req_o), 32'd1);
    chk("f1_stall_c1", 32'(if_stallreq_o), 32'd1);
    tick(); @(negedge clk); chk("f1_stall_ack", 32'(if_stallreq_o), 32'd0);
    tick(); if_ce_i = 1'b0;
    @(negedge clk); chk("f1_req_done", 32'(bus_req_o), 32'd0);
    wait_quiet("f1_quiet");

    // Simultaneous load and fetch under hold: data first, fetch after one IDLE cycle
    push(1'b1, 1'b0, 4'b1111, 32'h200, 32'h0, 32'h11112222, 1, 1'b1);
    push(1'b0, 1'b0, 4'b1111, 32'h104, 32'h0, 32'h33334444, 1, 1'b1);
    tick(); pipe_hold_i = 1'b1;
    if_ce_i = 1'b1; if_addr_i = 32'h104;
    dm_ce_i = 1'b1; dm_we_i = 1'b0; dm_sel_i = 4'b1111; dm_addr_i = 32'h200;
    @(negedge clk); chk("s2_dm_stall_c0", 32'(dm_stallreq_o), 32'd1);
    tick(); @(negedge clk); chk("s2_dm_stall_ack", 32'(dm_stallreq_o), 32'd0);
    tick(); @(negedge clk);
    chk("s2_idle_gap", 32'(bus_req_o), 32'd0);
    chk("s2_dm_stall_done", 32'(dm_stallreq_o), 32'd0);
    chk("s2_dm_hold", dm_rdata_o, 32'h11112222);
    chk("s2_if_stall_wait", 32'(if_stallreq_o), 32'd1);
    tick(); @(negedge clk);
    chk("s2_if_issue", bus_addr_o, 32'h104);
    chk("s2_if_stall_ack", 32'(if_stallreq_o), 32'd0);
    tick(); @(negedge clk);
    chk("s2_if_hold", if_rdata_o, 32'h33334444);
    chk("s2_stalls_done", 32'({if_stallreq_o, dm_stallreq_o}), 32'd0);
    tick(); @(negedge clk); chk("s2_no_reissue", 32'(bus_req_o), 32'd0);
    tick(); if_ce_i = 1'b0; dm_ce_i = 1'b0; pipe_hold_i = 1'b0;
    wait_quiet("s2_quiet");

    // Store under hold with fetch pending: one write, dm_done held until advance edge
    push(1'b1, 1'b1, 4'b1111, 32'h44, 32'hDEADBEEF, 32'h0, 2, 1'b0);
    push(1'b0, 1'b0, 4'b1111, 32'h108, 32'h0, 32'h55556666, 1, 1'b1);
    tick(); pipe_hold_i = 1'b1;
    dm_ce_i = 1'b1; dm_we_i = 1'b1; dm_sel_i = 4'b1111; dm_addr_i = 32'h44; dm_wdata_i = 32'hDEADBEEF;
    if_ce_i = 1'b1; if_addr_i = 32'h108;
    for (int i = 0; i < 7; i++) tick();
    @(negedge clk);
    chk("s3_idle", 32'(bus_req_o), 32'd0);
    chk("s3_stalls_held", 32'({if_stallreq_o, dm_stallreq_o}), 32'd0);
    chk("s3_if_hold", if_rdata_o, 32'h55556666);
    tick(); pipe_hold_i = 1'b0;
    @(negedge clk); chk("s3_done_before_adv", 32'(dm_stallreq_o), 32'd0);
    tick(); pipe_hold_i = 1'b1; if_ce_i = 1'b0;
    dm_addr_i = 32'h48; dm_wdata_i = 32'h0BADF00D;
    push(1'b1, 1'b1, 4'b1111, 32'h48, 32'h0BADF00D, 32'h0, 1, 1'b0);
    @(negedge clk); chk("s3_done_cleared", 32'(dm_stallreq_o), 32'd1);
    tick(); tick(); @(negedge clk); chk("s3_second_done", 32'(dm_stallreq_o), 32'd0);
    tick(); dm_ce_i = 1'b0; pipe_hold_i = 1'b0;
    wait_quiet("s3_quiet");

    // Byte store with ack delayed to the 5th request cycle
    push(1'b1, 1'b1, 4'b0010, 32'h47, 32'h0000AB00, 32'h0, 5, 1'b0);
    tick(); dm_ce_i = 1'b1; dm_we_i = 1'b1; dm_sel_i = 4'b0010; dm_addr_i = 32'h47; dm_wdata_i = 32'h0000AB00;
    for (int i = 1; i <= 4; i++) begin
      tick(); @(negedge clk);
      chk("b4_sel", 32'(bus_sel_o), 32'h2);
      chk("b4_addr", bus_addr_o, 32'h47);
      chk("b4_stall", 32'(dm_stallreq_o), 32'd1);
    end
    tick(); @(negedge clk); chk("b4_stall_ack", 32'(dm_stallreq_o), 32'd0);
    tick(); dm_ce_i = 1'b0;
    wait_quiet("b4_quiet");

    // Flush during fetch under hold: old result discarded, new fetch at 0x300 issued
    pipe_hold_i = 1'b1;
    push(1'b0, 1'b0, 4'b1111, 32'h10C, 32'h0, 32'hBAD0BAD0, 3, 1'b0);
    tick(); if_ce_i = 1'b1; if_addr_i = 32'h10C;
    tick(); flush_i = 1'b1;
    @(negedge clk); chk("f5_req_inst", 32'(bus_req_o), 32'd1);
    tick(); flush_i = 1'b0; if_addr_i = 32'h300;
    push(1'b0, 1'b0, 4'b1111, 32'h300, 32'h0, 32'h24020005, 1, 1'b1);
    tick(); tick(); @(negedge clk);
    chk("f5_no_stale_hold", if_rdata_o, 32'h55556666);
    chk("f5_still_stalled", 32'(if_stallreq_o), 32'd1);
    tick(); @(negedge clk); chk("f5_new_addr", bus_addr_o, 32'h300);
    tick(); @(negedge clk);
    chk("f5_new_hold", if_rdata_o, 32'h24020005);
    chk("f5_done", 32'(if_stallreq_o), 32'd0);
    tick(); if_ce_i = 1'b0; pipe_hold_i = 1'b0;
    wait_quiet("f5_quiet");

    // Reset in the middle of a data access
    push(1'b1, 1'b0, 4'b1111, 32'h500, 32'h0, 32'h12345678, 20, 1'b1);
    tick(); dm_ce_i = 1'b1; dm_we_i = 1'b0; dm_sel_i = 4'b1111; dm_addr_i = 32'h500;
    tick(); tick();
    #1 rst = 1'b0;
    #1;
    chk("r6_req_async", 32'(bus_req_o), 32'd0);
    chk("r6_addr", bus_addr_o, 32'h0);
    chk("r6_sel_we", 32'({bus_sel_o, bus_we_o}), 32'd0);
    chk("r6_wdata", bus_wdata_o, 32'h0);
    chk("r6_rdata", {dm_rdata_o[15:0], if_rdata_o[15:0]}, 32'h0);
    dm_ce_i = 1'b0; force_ack = 1'b1;
    tick(); tick(); rst = 1'b1;
    tick(); @(negedge clk);
    chk("r6_ack_ignored", 32'(bus_req_o), 32'd0);
    chk("r6_dm_rdata", dm_rdata_o, 32'h0);
    tick(); force_ack = 1'b0;
    wait_quiet("r6_quiet");
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
